prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 17'd0, first program-memory address written.
REQ-002 SHALL provide parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 i_clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset, sampled on the rising edge of i_clock.
REQ-005 i_byte  input  8  incoming stream byte.
REQ-006 i_valid  input  1  i_byte valid this cycle.
REQ-007 o_ready  output  1  loader accepts i_byte this cycle.
REQ-008 o_we  output  1  program-memory write strobe, one cycle per instruction.
REQ-009 o_addr  output  17  program-memory write address.
REQ-010 o_data  output  19  instruction word to write.
REQ-011 o_hold  output  1  holds the CPU (instruction pointer and stack) while high.
REQ-012 o_done  output  1  frame loaded and checksum good; sticky until reset.
REQ-013 o_error  output  1  checksum mismatch; sticky until reset.

Function
REQ-014 Byte transfer SHALL occur only on cycles with i_valid=1 and o_ready=1; i_byte SHALL be ignored otherwise.
REQ-015 Frame format SHALL be: SYNC_BYTE, count high, count low (N, 16 bits), N x 3 instruction bytes, 1 checksum byte.
REQ-016 Instruction bytes SHALL be big-endian: o_data = {b0[2:0], b1, b2}; b0[7:3] SHALL be ignored for data but included in the checksum.
REQ-017 The checksum SHALL be the 8-bit modulo-256 sum of the count bytes and all instruction bytes, excluding SYNC_BYTE.
REQ-018 States SHALL be IDLE, CNT_H, CNT_L, B0, B1, B2, WRITE, CSUM, DONE, ERR.
REQ-019 IDLE: a byte equal to SYNC_BYTE SHALL go to CNT_H; any other accepted byte SHALL be discarded with the FSM remaining in IDLE.
REQ-020 CNT_H -> CNT_L on accept; CNT_L -> B0 if N!=0, else -> CSUM.
REQ-021 B0 -> B1 -> B2 on each accept; B2 accept SHALL go to WRITE.
REQ-022 WRITE SHALL last exactly one cycle, with o_we=1, o_addr = BASE_ADDR + word index, o_data = assembled word, and o_ready=0.
REQ-023 After WRITE, the FSM SHALL go to B0 if the remaining count is nonzero, else to CSUM.
REQ-024 CSUM accept SHALL go to DONE if the byte equals the running sum, else to ERR.
REQ-025 o_ready SHALL be 1 in IDLE, CNT_H, CNT_L, B0, B1, B2 and CSUM, and 0 in WRITE, DONE and ERR.
REQ-026 o_hold SHALL be 1 in every state except DONE.
REQ-027 DONE and ERR SHALL be terminal; only i_reset exits them.
REQ-028 o_addr SHALL wrap modulo 2^17; with N up to 65535, no other overflow is possible.
REQ-029 o_we SHALL be 0 in every state except WRITE.
REQ-030 o_addr and o_data SHALL hold their last values outside WRITE.
REQ-031 There SHALL be no inter-byte timeout; i_valid gaps of any length SHALL be tolerated.

Reset
REQ-032 On i_reset=1: state IDLE, o_hold=1, o_ready=1, o_we=0, o_done=0, o_error=0, o_addr=BASE_ADDR, o_data=0, count=0, checksum=0.
REQ-033 Reset asserted mid-frame (including during WRITE) SHALL abort the frame, suppress o_we in that cycle, and discard all partial state.

Verification
REQ-034 Stream A5 00 01 05 12 34 4C -> one o_we pulse, o_addr=0, o_data=19'h51234; then o_done=1, o_hold=0.
REQ-035 Stream A5 00 00 00 -> no o_we; o_done=1.
REQ-036 Stream A5 00 01 05 12 34 00 -> one write; then o_error=1, o_hold=1, o_done=0.
REQ-037 Stream 11 22 A5 00 02 + 6 data bytes + correct sum -> the first two bytes are discarded; writes land at o_addr 0 and 1; o_ready=0 in both WRITE cycles.
REQ-038 Reset pulsed after the B1 byte, then a valid single-word frame -> no write from the aborted frame; the new frame is written at BASE_ADDR.
REQ-039 Random i_valid gaps over a 3-word frame -> identical writes, and no accept while o_ready=0.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, program-memory write port and status out
interface prog_loader_if;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic        o_we;
  logic [16:0] o_addr;
  logic [18:0] o_data;
  logic        o_hold;
  logic        o_done;
  logic        o_error;
  modport slave (
    input  i_byte, i_valid,
    output o_ready, o_we, o_addr, o_data, o_hold, o_done, o_error
  );
  modport master (
    output i_byte, i_valid,
    input  o_ready, o_we, o_addr, o_data, o_hold, o_done, o_error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses a sync/count/words/checksum frame and writes program memory
module prog_loader #(
  parameter logic [16:0] BASE_ADDR = 17'd0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic         i_clock,
  input logic         i_reset,
  prog_loader_if.slave bus
);
  typedef enum logic [3:0] {IDLE, CNT_H, CNT_L, B0, B1, B2, WRITE, CSUM, DONE, ERR} state_t;
  state_t      state, next;
  logic [15:0] cnt;
  logic [7:0]  sum;
  logic [2:0]  b0;
  logic [7:0]  b1;
  logic [16:0] idx;
  logic        acc;
  assign bus.o_ready = state inside {IDLE, CNT_H, CNT_L, B0, B1, B2, CSUM};
  assign acc         = bus.i_valid && bus.o_ready;
  // a reset landing on a WRITE cycle must not let that write escape
  assign bus.o_we    = state == WRITE && !i_reset;
  assign bus.o_hold  = state != DONE;
  assign bus.o_done  = state == DONE;
  assign bus.o_error = state == ERR;
  // state register; DONE and ERR are only left through reset
  always_ff @(posedge i_clock)
    state <= i_reset ? IDLE : next;
  // next-state decode, advancing only on accepted bytes except for WRITE
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = acc && bus.i_byte == SYNC_BYTE ? CNT_H : IDLE;
      CNT_H:   next = acc ? CNT_L : CNT_H;
      CNT_L:   next = !acc ? CNT_L : {cnt[15:8], bus.i_byte} != 16'd0 ? B0 : CSUM;
      B0:      next = acc ? B1 : B0;
      B1:      next = acc ? B2 : B1;
      B2:      next = acc ? WRITE : B2;
      WRITE:   next = cnt != 16'd1 ? B0 : CSUM;
      CSUM:    next = !acc ? CSUM : bus.i_byte == sum ? DONE : ERR;
      default: next = state;
    endcase
  end
  // datapath: count, running sum, word assembly; the write port is loaded on
  // the last byte so it is stable for WRITE and holds afterwards
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt        <= '0;
      sum        <= '0;
      b0         <= '0;
      b1         <= '0;
      idx        <= '0;
      bus.o_addr <= BASE_ADDR;
      bus.o_data <= '0;
    end else begin
      if (acc && state inside {CNT_H, CNT_L, B0, B1, B2})
        sum <= sum + bus.i_byte;
      if (acc && state == CNT_H) cnt[15:8] <= bus.i_byte;
      if (acc && state == CNT_L) cnt[7:0] <= bus.i_byte;
      if (acc && state == B0) b0 <= bus.i_byte[2:0];
      if (acc && state == B1) b1 <= bus.i_byte;
      if (acc && state == B2) begin
        bus.o_data <= {b0, b1, bus.i_byte};
        bus.o_addr <= BASE_ADDR + idx;
      end
      if (state == WRITE) begin
        cnt <= cnt - 16'd1;
        idx <= idx + 17'd1;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven frames plus reset/gap sequences, writes checked via scoreboard
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  prog_loader_if bus();
  prog_loader dut (.i_clock(clk), .i_reset(rst), .bus(bus));
  typedef struct packed {
    logic [95:0] b;
    logic [3:0]  len;
    logic        done;
    logic        err;
    logic [1:0]  nw;
    logic [35:0] w0;
    logic [35:0] w1;
  } vec_t;
  vec_t        vecs [4];
  logic [35:0] exp_q [$];
  int          checks = 0;
  int          fails = 0;
  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // every write cycle is matched against the next expected {addr,data}
  always @(negedge clk) begin
    if (bus.o_we) begin
      chk("ready_in_write", {35'd0, bus.o_ready}, 36'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.o_addr, bus.o_data);
      end else chk("write_addr_data", {bus.o_addr, bus.o_data}, exp_q.pop_front());
    end
  end
  task automatic send(input logic [7:0] b, input int gap);
    bus.i_byte  = b;
    bus.i_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.o_ready) break;
      if (t == 50) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout: got ready 0 expected ready 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_byte  = 8'hFF;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic chk_end(input string tag, input logic done, input logic err);
    @(negedge clk);
    chk({tag, "_done"}, {35'd0, bus.o_done}, {35'd0, done});
    chk({tag, "_error"}, {35'd0, bus.o_error}, {35'd0, err});
    chk({tag, "_hold"}, {35'd0, bus.o_hold}, {35'd0, !done});
    chk({tag, "_ready"}, {35'd0, bus.o_ready}, 36'd0);
    chk({tag, "_pending"}, 36'(exp_q.size()), 36'd0);
    exp_q.delete();
  endtask
  initial begin
    logic [7:0]  fb [12];
    logic [7:0]  s;
    logic [35:0] last;
    vecs[0] = '{b: 96'hA5_00_01_05_12_34_4C_00_00_00_00_00, len: 4'd7, done: 1'b1, err: 1'b0,
                nw: 2'd1, w0: {17'd0, 19'h51234}, w1: 36'd0};
    vecs[1] = '{b: 96'hA5_00_00_00_00_00_00_00_00_00_00_00, len: 4'd4, done: 1'b1, err: 1'b0,
                nw: 2'd0, w0: 36'd0, w1: 36'd0};
    vecs[2] = '{b: 96'hA5_00_01_05_12_34_00_00_00_00_00_00, len: 4'd7, done: 1'b0, err: 1'b1,
                nw: 2'd1, w0: {17'd0, 19'h51234}, w1: 36'd0};
    vecs[3] = '{b: 96'h11_22_A5_00_02_01_02_03_84_05_06_97, len: 4'd12, done: 1'b1, err: 1'b0,
                nw: 2'd2, w0: {17'd0, 19'h10203}, w1: {17'd1, 19'h40506}};
    bus.i_byte  = 8'h00;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {35'd0, bus.o_hold}, 36'd1);
    chk("rst_ready", {35'd0, bus.o_ready}, 36'd1);
    chk("rst_we", {35'd0, bus.o_we}, 36'd0);
    chk("rst_done", {35'd0, bus.o_done}, 36'd0);
    chk("rst_error", {35'd0, bus.o_error}, 36'd0);
    chk("rst_addr_data", {bus.o_addr, bus.o_data}, 36'd0);
    rst = 1'b0;
    for (int v = 0; v < 4; v++) begin
      pulse_reset();
      if (vecs[v].nw > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].nw > 1) exp_q.push_back(vecs[v].w1);
      for (int i = 0; i < int'(vecs[v].len); i++)
        send(vecs[v].b[95-8*i -: 8], i % 2);
      chk_end($sformatf("vec%0d", v), vecs[v].done, vecs[v].err);
    end
    bus.i_byte  = 8'hA5;
    bus.i_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("terminal_done", {35'd0, bus.o_done}, 36'd1);
    chk("terminal_hold", {35'd0, bus.o_hold}, 36'd0);
    pulse_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h05, 0); send(8'h12, 0);
    pulse_reset();
    exp_q.push_back({17'd0, 19'h7ABCD});
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h07, 0);
    send(8'hAB, 0); send(8'hCD, 0); send(8'h80, 0);
    chk_end("abort_b1", 1'b1, 1'b0);
    pulse_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h05, 0); send(8'h12, 0); send(8'h34, 0);
    rst = 1'b1;
    #1;
    chk("we_suppressed", {35'd0, bus.o_we}, 36'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_write_ready", {35'd0, bus.o_ready}, 36'd1);
    exp_q.push_back({17'd0, 19'h60001});
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h06, 0);
    send(8'h00, 0); send(8'h01, 0); send(8'h08, 0);
    chk_end("abort_write", 1'b1, 1'b0);
    pulse_reset();
    fb[0] = 8'hA5;
    fb[1] = 8'h00;
    fb[2] = 8'h03;
    s = 8'h03;
    for (int i = 3; i < 12; i++) begin
      fb[i] = 8'($urandom_range(0, 255));
      s = s + fb[i];
    end
    for (int k = 0; k < 3; k++) begin
      last = {17'(k), fb[3+3*k][2:0], fb[4+3*k], fb[5+3*k]};
      exp_q.push_back(last);
    end
    for (int i = 0; i < 12; i++) send(fb[i], $urandom_range(0, 4));
    send(s, 0);
    chk_end("gaps", 1'b1, 1'b0);
    chk("gaps_hold_addr_data", {bus.o_addr, bus.o_data}, last);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
